emif16_async_master: RTL and testbench
======================================

# emif16_async_master

Synthesizable EMIF16 asynchronous-bus master that sequences one external-memory access at a time through programmable setup / strobe / hold / turnaround phases. It accepts word-wide commands on a valid/ready port, drives the 16-bit EMIF pins, and optionally extends the strobe with the external WAIT pin. It is the RTL counterpart of the behavioural EMIF16 model and sits between the bridge command logic and the chip-select-0 async memory pins.

## Interface
- TA_W, 2: width of the turnaround field.
- clk_i  in  1  system clock (166 MHz nominal).
- rst_i  in  1  synchronous, active-high reset.
- cfg_i  in  emif16_cfg_t  timing/mode config; latched on command accept.
- wait_timeout_i  in  8  maximum extended-wait cycles; 0 = no timeout.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid and ready are both high.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  24  word address.
- cmd_be_i  in  2  byte enables, active-high.
- cmd_wdata_i  in  16  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  16  read data; held until next read completes.
- rsp_err_o  out  1  wait timeout; qualified by rsp_valid_o.
- e_data_io  inout  16  EMIF data bus.
- e_addr_o  out  24  EMIF address.
- e_ben_o  out  2  byte enables, active-low.
- e_cen_o  out  1  chip enable, active-low.
- e_wait_i  in  1  WAIT from the memory; high = wait asserted.
- e_wen_o  out  1  write strobe, active-low.
- e_oen_o  out  1  output enable, active-low.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TA.
- IDLE: cmd_ready_o=1. On accept, latch cmd and cfg, then go to SETUP. cmd_ready_o=0 in every other state.
- Phase lengths: setup field 4 bit, strobe field 6 bit, hold field 3 bit, ta field TA_W bit. A field value N gives N+1 cycles. A single down-counter is reloaded on each phase entry.
- SETUP: e_addr_o and e_ben_o (= ~be) are valid. For a write, the bus is driven with wdata. e_cen_o=0 when cfg.ss=0.
- STROBE:
  - e_wen_o=0 for a write, or e_oen_o=0 for a read.
  - e_cen_o=0 in both ss modes.
  - At counter expiry, if cfg.ew=1 and the synchronized wait is high, remain in STROBE and increment the wait counter.
  - Exit when synchronized wait is low, or when the wait counter equals a non-zero wait_timeout_i (sets the error flag).
- Read data is captured from e_data_io at the clock edge that ends STROBE.
- HOLD: strobes are high. Address, ben, write data and cen (ss=0) are held.
- TA: all controls are inactive and the bus is released. rsp_valid_o pulses on the first TA cycle. Return to IDLE after TA.
- The bus is driven only by writes, from SETUP through HOLD. Reads never drive it.
- e_wait_i passes through a 2-flop synchronizer. Its latency is absorbed by the minimum strobe.
- All EMIF outputs are registered.

## Timing
- Reset values: e_cen_o=1, e_wen_o=1, e_oen_o=1, e_ben_o=2'b11, e_addr_o=0, bus hi-Z, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, state IDLE (cmd_ready_o=1 from the first cycle after reset).
- Accept at edge k: SETUP begins at cycle k+1.
- Total latency without wait = (S+1)+(T+1)+(H+1) cycles, then rsp_valid_o. Back-to-back throughput adds (TA+1)+1 IDLE cycles.
- Reset mid-access: at the next edge all strobes are high, cen is high, the bus is released, and no response is issued.
- cfg_i or wait_timeout_i changing mid-access has no effect until the next accept.
- cmd_valid_i while busy: the command is held and not lost.

## Configuration
- EMIF16_MASTER_EW_EN defined: extended-wait logic is present, including the synchronizer, wait counter, timeout and rsp_err_o.
- Not defined:
  - cfg.ew and e_wait_i are ignored.
  - STROBE always lasts exactly T+1 cycles.
  - rsp_err_o is tied to 0.

## Structure
- emif16_pkg:
  - emif16_cfg_t packed struct {ew, ss, w_setup, w_strobe, w_hold, r_setup, r_strobe, r_hold, ta}.
  - State enum emif16_state_e.
  - Field-width localparams.
- Sub-module emif16_sync: generic 2-flop synchronizer, used for e_wait_i.

## Test plan
- Write addr 0x00A5A5, be=2'b11, data 0x1234, setup/strobe/hold = 1/3/1 (2/4/2 cycles) → e_wen_o low for exactly 4 cycles. The slave stores 0x1234 and rsp_valid_o fires 8 cycles after accept.
- Read back the same address with be=2'b01 → e_oen_o low 4 cycles, e_ben_o=2'b10, rsp_rdata_o[7:0]=0x34, bus never driven by the DUT.
- ss=1 vs ss=0 on the same write → e_cen_o low only during STROBE vs from SETUP through HOLD.
- ew=1, slave holds WAIT high for 12 cycles after the strobe falls → strobe extends until the synchronized wait drops. Data is correct and rsp_err_o=0.
- ew=1, wait_timeout_i=5, WAIT stuck high → strobe ends after min strobe + 5 cycles, with rsp_valid_o=1 and rsp_err_o=1.
- rst_i asserted during STROBE of a write → all strobes and cen high and the bus hi-Z after one edge. No rsp_valid_o. The next command completes normally.

Source files
------------

// File: rtl/emif16_pkg.sv
// emif16_pkg: shared types for the EMIF16 async master.
// Config struct, FSM state encoding, field widths and phase-counter reload helpers.
package emif16_pkg;

  localparam int EMIF16_SETUP_W  = 4;
  localparam int EMIF16_STROBE_W = 6;
  localparam int EMIF16_HOLD_W   = 3;
  localparam int EMIF16_TA_W     = 2;
  localparam int EMIF16_CNT_W    = 6;   // wide enough for the longest phase field
  localparam int EMIF16_ADDR_W   = 24;
  localparam int EMIF16_DATA_W   = 16;
  localparam int EMIF16_WCNT_W   = 8;

  typedef struct packed {
    logic                       ew;        // honour external WAIT
    logic                       ss;        // select-strobe: cen only during STROBE
    logic [EMIF16_SETUP_W-1:0]  w_setup;
    logic [EMIF16_STROBE_W-1:0] w_strobe;
    logic [EMIF16_HOLD_W-1:0]   w_hold;
    logic [EMIF16_SETUP_W-1:0]  r_setup;
    logic [EMIF16_STROBE_W-1:0] r_strobe;
    logic [EMIF16_HOLD_W-1:0]   r_hold;
    logic [EMIF16_TA_W-1:0]     ta;
  } emif16_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TA     = 3'd4
  } emif16_state_e;

  // A field value N is loaded as N so the phase lasts N+1 cycles (ends at count 0).
  function automatic logic [EMIF16_CNT_W-1:0] setup_load(emif16_cfg_t c, logic wr);
    return wr ? EMIF16_CNT_W'(c.w_setup) : EMIF16_CNT_W'(c.r_setup);
  endfunction

  function automatic logic [EMIF16_CNT_W-1:0] strobe_load(emif16_cfg_t c, logic wr);
    return wr ? EMIF16_CNT_W'(c.w_strobe) : EMIF16_CNT_W'(c.r_strobe);
  endfunction

  function automatic logic [EMIF16_CNT_W-1:0] hold_load(emif16_cfg_t c, logic wr);
    return wr ? EMIF16_CNT_W'(c.w_hold) : EMIF16_CNT_W'(c.r_hold);
  endfunction

endpackage

// File: rtl/emif16_async_master_sync.sv
// emif16_sync: generic W-bit two-flop synchronizer with synchronous reset.
module emif16_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops; only sync_q is safe to use downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/emif16_async_master.sv
// emif16_async_master: one-access-at-a-time EMIF16 async master (chip-select 0).
// Optional feature macro: EMIF16_MASTER_EW_EN adds extended-wait support
// (WAIT synchronizer, wait counter, timeout, rsp_err_o). Without it WAIT is ignored.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a command; EMIF controls inactive
// ST_SETUP  | address/ben valid, write data driven, cen low if ss=0
// ST_STROBE | wen or oen low, cen low; may stretch on synchronized WAIT
// ST_HOLD   | strobes high, address/ben/data/cen(ss=0) held
// ST_TA     | everything released; rsp_valid_o on the first cycle
module emif16_async_master
  import emif16_pkg::*;
#(
  parameter int TA_W = EMIF16_TA_W   // must match the ta field of emif16_cfg_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  emif16_cfg_t              cfg_i,
  input  logic [EMIF16_WCNT_W-1:0] wait_timeout_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [EMIF16_ADDR_W-1:0] cmd_addr_i,
  input  logic [1:0]               cmd_be_i,
  input  logic [EMIF16_DATA_W-1:0] cmd_wdata_i,
  output logic                     rsp_valid_o,
  output logic [EMIF16_DATA_W-1:0] rsp_rdata_o,
  output logic                     rsp_err_o,
  inout  wire  [EMIF16_DATA_W-1:0] e_data_io,
  output logic [EMIF16_ADDR_W-1:0] e_addr_o,
  output logic [1:0]               e_ben_o,
  output logic                     e_cen_o,
  input  logic                     e_wait_i,
  output logic                     e_wen_o,
  output logic                     e_oen_o
);

  emif16_state_e              state_q;
  emif16_cfg_t                cfg_q;
  logic                       ready_q;
  logic                       write_q;
  logic [EMIF16_CNT_W-1:0]    cnt_q;
  logic [EMIF16_WCNT_W-1:0]   wait_cnt_q;
  logic [EMIF16_WCNT_W-1:0]   timeout_q;
  logic                       err_q;
  logic [EMIF16_ADDR_W-1:0]   e_addr_q;
  logic [1:0]                 e_ben_q;
  logic                       e_cen_q;
  logic                       e_wen_q;
  logic                       e_oen_q;
  logic [EMIF16_DATA_W-1:0]   dout_q;
  logic                       drive_q;
  logic                       rsp_valid_q;
  logic                       rsp_err_q;
  logic [EMIF16_DATA_W-1:0]   rdata_q;
  logic [TA_W-1:0]            ta_len;

  logic wait_sync;
  logic wait_hold;     // strobe must stretch this cycle if it has expired
  logic timeout_hit;   // wait counter reached a non-zero timeout

  assign ta_len = cfg_q.ta;

`ifdef EMIF16_MASTER_EW_EN
  emif16_sync #(.W(1)) u_wait_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (e_wait_i),
    .q_o   (wait_sync)
  );

  assign wait_hold   = cfg_q.ew && wait_sync;
  assign timeout_hit = (timeout_q != '0) && (wait_cnt_q == timeout_q);
  assign rsp_err_o   = rsp_err_q;
`else
  logic unused_ew;
  assign unused_ew   = ^{e_wait_i, cfg_q.ew, timeout_q, wait_cnt_q, rsp_err_q};
  assign wait_sync   = 1'b0;
  assign wait_hold   = wait_sync;
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;
`endif

  // Access sequencer: all EMIF pins and response signals are set on state transitions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      ready_q     <= 1'b1;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= '0;
      err_q       <= 1'b0;
      e_addr_q    <= '0;
      e_ben_q     <= 2'b11;
      e_cen_q     <= 1'b1;
      e_wen_q     <= 1'b1;
      e_oen_q     <= 1'b1;
      dout_q      <= '0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            state_q    <= ST_SETUP;
            ready_q    <= 1'b0;
            cfg_q      <= cfg_i;
            write_q    <= cmd_write_i;
            timeout_q  <= wait_timeout_i;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            e_addr_q   <= cmd_addr_i;
            e_ben_q    <= ~cmd_be_i;
            e_cen_q    <= cfg_i.ss;
            dout_q     <= cmd_wdata_i;
            drive_q    <= cmd_write_i;
            cnt_q      <= setup_load(cfg_i, cmd_write_i);
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_STROBE;
            e_cen_q <= 1'b0;
            e_wen_q <= ~write_q;
            e_oen_q <= write_q;
            cnt_q   <= strobe_load(cfg_q, write_q);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (wait_hold && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end else begin
            // Leaving with WAIT still asserted can only mean the timeout fired.
            state_q <= ST_HOLD;
            err_q   <= wait_hold;
            e_wen_q <= 1'b1;
            e_oen_q <= 1'b1;
            e_cen_q <= cfg_q.ss;
            cnt_q   <= hold_load(cfg_q, write_q);
            if (!write_q) begin
              rdata_q <= e_data_io;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q     <= ST_TA;
            e_cen_q     <= 1'b1;
            e_ben_q     <= 2'b11;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            cnt_q       <= EMIF16_CNT_W'(ta_len);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_TA: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign e_data_io   = drive_q ? dout_q : {EMIF16_DATA_W{1'bz}};
  assign cmd_ready_o = ready_q;
  assign e_addr_o    = e_addr_q;
  assign e_ben_o     = e_ben_q;
  assign e_cen_o     = e_cen_q;
  assign e_wen_o     = e_wen_q;
  assign e_oen_o     = e_oen_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_emif16_async_master.sv
// tb_emif16_async_master: scoreboard bench for emif16_async_master with a
// behavioural async SRAM slave and a programmable WAIT generator.
module tb_emif16_async_master;
  import emif16_pkg::*;

`ifdef EMIF16_MASTER_EW_EN
  localparam bit EW = 1'b1;
`else
  localparam bit EW = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          strobe;
    int          cen_lo;
    int          cen_out;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  emif16_cfg_t cfg;
  logic [7:0]  tmo;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [23:0] cmd_addr;
  logic [1:0]  cmd_be;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  wire  [15:0] e_data;
  logic [23:0] e_addr;
  logic [1:0]  e_ben;
  logic        e_cen;
  logic        e_wait = 1'b0;
  logic        e_wen;
  logic        e_oen;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  logic [15:0] mem [256];
  logic        mem_clr;
  int          wait_len = 0;
  logic        wait_stuck = 1'b0;
  int          wcnt = 0;
  logic        strb_prev = 1'b0;

  always #5 clk = ~clk;

  emif16_async_master dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_i          (cfg),
    .wait_timeout_i (tmo),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_write_i    (cmd_write),
    .cmd_addr_i     (cmd_addr),
    .cmd_be_i       (cmd_be),
    .cmd_wdata_i    (cmd_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .e_data_io      (e_data),
    .e_addr_o       (e_addr),
    .e_ben_o        (e_ben),
    .e_cen_o        (e_cen),
    .e_wait_i       (e_wait),
    .e_wen_o        (e_wen),
    .e_oen_o        (e_oen)
  );

  // Slave drives the bus only while selected and output-enabled.
  assign e_data = (!e_cen && !e_oen) ? mem[e_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else if (!e_cen && !e_wen) begin
      if (!e_ben[0]) mem[e_addr[7:0]][7:0]  <= e_data[7:0];
      if (!e_ben[1]) mem[e_addr[7:0]][15:8] <= e_data[15:8];
    end
  end

  // WAIT: held high for wait_len cycles from the cycle the strobe falls, or stuck high.
  always @(negedge clk) begin
    strb_prev <= !e_wen || !e_oen;
    if ((!e_wen || !e_oen) && !strb_prev && wait_len > 0) begin
      wcnt   <= wait_len;
      e_wait <= 1'b1;
    end else begin
      wcnt   <= (wcnt > 0) ? wcnt - 1 : 0;
      e_wait <= wait_stuck || (wcnt > 1);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic bus_driven();
    return !(e_data === 16'hzzzz || e_data === 16'h0000);
  endfunction

  function automatic exp_t mk_exp(logic wr, logic [15:0] rd, logic err, int lat,
                                  int strobe, int cen_lo, int cen_out);
    exp_t e;
    e.wr = wr; e.rdata = rd; e.err = err; e.lat = lat;
    e.strobe = strobe; e.cen_lo = cen_lo; e.cen_out = cen_out;
    return e;
  endfunction

  // Issue one command, monitor the access cycle by cycle, compare against the scoreboard.
  task automatic run_cmd(input logic wr, input logic [23:0] addr, input logic [1:0] be,
                         input logic [15:0] wd, input emif16_cfg_t c, input logic [7:0] to,
                         input exp_t e);
    int          n;
    int          cyc;
    int          wen_lo;
    int          oen_lo;
    int          cen_lo;
    int          cen_out;
    int          rd_drv;
    logic        got;
    logic [15:0] bus_s;
    logic [1:0]  ben_exp;
    exp_t        x;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_be = be; cmd_wdata = wd;
    cfg = c; tmo = to;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cfg = emif16_cfg_t'(30'($urandom));
    tmo = 8'($urandom);
    cmd_addr = 24'($urandom);
    cmd_wdata = 16'($urandom);
    ben_exp = ~be;
    check_val("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    check_val("e_addr", 32'(e_addr), 32'(addr));
    check_val("e_ben", 32'(e_ben), 32'(ben_exp));
    cyc = 0; wen_lo = 0; oen_lo = 0; cen_lo = 0; cen_out = 0; rd_drv = 0;
    got = 1'b0; bus_s = 16'h0;
    while (cyc < 300) begin
      if (rsp_valid) begin got = 1'b1; break; end
      if (!e_wen) begin wen_lo++; if (wen_lo == 1) bus_s = e_data; end
      if (!e_oen) oen_lo++;
      if (e_oen && bus_driven()) rd_drv++;
      if (!e_cen) begin cen_lo++; if (e_wen && e_oen) cen_out++; end
      @(negedge clk);
      cyc++;
    end
    check_val("rsp_seen", 32'(got), 32'd1);
    x = sb_q.pop_front();
    check_val("latency", 32'(cyc), 32'(x.lat));
    check_val("strobe_len", 32'(x.wr ? wen_lo : oen_lo), 32'(x.strobe));
    check_val("wrong_strobe", 32'(x.wr ? oen_lo : wen_lo), 32'd0);
    check_val("cen_low", 32'(cen_lo), 32'(x.cen_lo));
    check_val("cen_outside_strobe", 32'(cen_out), 32'(x.cen_out));
    check_val("rsp_err", 32'(rsp_err), 32'(x.err));
    if (x.wr) check_val("wr_bus_data", 32'(bus_s), 32'(wd));
    else begin
      check_val("rdata", 32'(rsp_rdata), 32'(x.rdata));
      check_val("rd_bus_driven", 32'(rd_drv), 32'd0);
    end
    @(negedge clk);
    check_val("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check_val("ta_bus_released", 32'(bus_driven()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    emif16_cfg_t base;
    emif16_cfg_t c;
    int          n;
    int          rsp_cnt;
    logic [15:0] m;

    base = '0;
    base.w_setup = 4'd1; base.w_strobe = 6'd3; base.w_hold = 3'd1;
    base.r_setup = 4'd1; base.r_strobe = 6'd3; base.r_hold = 3'd1;
    base.ta = 2'd1;

    rst = 1'b1; mem_clr = 1'b1; cfg = base; tmo = 8'd0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check_val("rst_cen", 32'(e_cen), 32'd1);
    check_val("rst_wen", 32'(e_wen), 32'd1);
    check_val("rst_oen", 32'(e_oen), 32'd1);
    check_val("rst_ben", 32'(e_ben), 32'd3);
    check_val("rst_addr", 32'(e_addr), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_val("rst_rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_bus", 32'(bus_driven()), 32'd0);

    // Basic write then read-back, ss=0.
    run_cmd(1'b1, 24'h00A5A5, 2'b11, 16'h1234, base, 8'd0,
            mk_exp(1'b1, 16'h0, 1'b0, 8, 4, 8, 4));
    m = mem[8'hA5];
    check_val("slave_mem_wr", 32'(m), 32'h1234);
    run_cmd(1'b0, 24'h00A5A5, 2'b01, 16'h0000, base, 8'd0,
            mk_exp(1'b0, 16'h1234, 1'b0, 8, 4, 8, 4));

    // ss=1: cen only during STROBE; upper-byte write then full read.
    c = base; c.ss = 1'b1;
    run_cmd(1'b1, 24'h00A5A5, 2'b10, 16'h5678, c, 8'd0,
            mk_exp(1'b1, 16'h0, 1'b0, 8, 4, 4, 0));
    run_cmd(1'b0, 24'h00A5A5, 2'b11, 16'h0000, c, 8'd0,
            mk_exp(1'b0, 16'h5634, 1'b0, 8, 4, 4, 0));

    // Extended wait: WAIT high 12 cycles from strobe fall.
    c = base; c.ew = 1'b1;
    wait_len = 12;
    run_cmd(1'b1, 24'h000010, 2'b11, 16'h0F0F, c, 8'd0,
            EW ? mk_exp(1'b1, 16'h0, 1'b0, 19, 15, 19, 4)
               : mk_exp(1'b1, 16'h0, 1'b0, 8, 4, 8, 4));
    wait_len = 0;
    run_cmd(1'b0, 24'h000010, 2'b11, 16'h0000, base, 8'd0,
            mk_exp(1'b0, 16'h0F0F, 1'b0, 8, 4, 8, 4));

    // Timeout: WAIT stuck high, timeout 5.
    wait_stuck = 1'b1;
    run_cmd(1'b0, 24'h000010, 2'b11, 16'h0000, c, 8'd5,
            EW ? mk_exp(1'b0, 16'h0F0F, 1'b1, 13, 9, 13, 4)
               : mk_exp(1'b0, 16'h0F0F, 1'b0, 8, 4, 8, 4));
    wait_stuck = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during STROBE of a write.
    c = base; c.w_strobe = 6'd10;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 24'h000020; cmd_be = 2'b11;
    cmd_wdata = 16'hBEEF; cfg = c;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (e_wen && n < 20) begin @(negedge clk); n++; end
    check_val("rst_test_strobe_seen", 32'(e_wen), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_wen", 32'(e_wen), 32'd1);
    check_val("midrst_oen", 32'(e_oen), 32'd1);
    check_val("midrst_cen", 32'(e_cen), 32'd1);
    check_val("midrst_bus", 32'(bus_driven()), 32'd0);
    rsp_cnt = (rsp_valid) ? 1 : 0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check_val("midrst_no_rsp", 32'(rsp_cnt), 32'd0);
    check_val("midrst_ready", 32'(cmd_ready), 32'd1);

    // Normal access after the aborted one.
    run_cmd(1'b0, 24'h00A5A5, 2'b11, 16'h0000, base, 8'd0,
            mk_exp(1'b0, 16'h5634, 1'b0, 8, 4, 8, 4));

    check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
